// File: rtl/f8_intc.sv
// f8_intc: 8-line interrupt controller driving the f8 core interrupt input.
// Define F8_INTC_LEVEL_EN to build level-mode support and the EDGE_SEL register.
module f8_intc #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  input  logic               reg_we,
  output logic [7:0]         reg_rdata,
  output logic               interrupt,
  output logic [15:0]        int_vector,
  input  logic               int_ack,
  output logic               int_active
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t state, state_nx;

  logic [NUM_IRQ-1:0] s1, s2, s3;
  logic [NUM_IRQ-1:0] enable, pending, pending_nx;
  logic [NUM_IRQ-1:0] req, edge_det, w1c, ack_clr;
  logic [7:0]         en8, pend8, esel8;
  logic [2:0]         idx, idx_nx, win;
  logic [15:0]        vec_nx;
  logic               gie, gie_nx;
  logic               irq_nx, act_nx;
  logic               any, ack, ctrl_wr;

`ifdef F8_INTC_LEVEL_EN
  logic [NUM_IRQ-1:0] edge_sel;
`endif

  assign ctrl_wr  = reg_we && (reg_addr == 2'd3);
  assign ack      = (state == REQ) && int_ack;
  assign edge_det = s2 & ~s3;
  assign w1c      = (reg_we && reg_addr == 2'd1)
                  ? reg_wdata[NUM_IRQ-1:0] : '0;
  assign req      = pending & enable;
  assign any      = |req;

  always_comb begin
    en8   = '0;
    pend8 = '0;
    esel8 = '0;
    en8[NUM_IRQ-1:0]   = enable;
    pend8[NUM_IRQ-1:0] = pending;
`ifdef F8_INTC_LEVEL_EN
    esel8[NUM_IRQ-1:0] = edge_sel;
`endif
  end

  // Lowest index wins
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req[i]) win = 3'(i);
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      ack_clr[i] = ack && (idx == 3'(i));
  end

  // A new edge beats any clear landing in the same cycle
  always_comb begin
    pending_nx = edge_det | (pending & ~(w1c | ack_clr));
`ifdef F8_INTC_LEVEL_EN
    pending_nx = (pending_nx & edge_sel) | (s2 & ~edge_sel);
`endif
  end

  always_comb begin
    state_nx = state;
    irq_nx   = interrupt;
    act_nx   = int_active;
    vec_nx   = int_vector;
    idx_nx   = idx;
    gie_nx   = gie;
    if (ctrl_wr) gie_nx = reg_wdata[7];
    unique case (state)
      IDLE: begin
        if (gie && any) begin
          state_nx = REQ;
          irq_nx   = 1'b1;
          idx_nx   = win;
          vec_nx   = VECTOR_BASE + {11'b0, win, 2'b00};
        end
      end
      REQ: begin
        if (int_ack) begin
          state_nx = SERVICE;
          irq_nx   = 1'b0;
          act_nx   = 1'b1;
          gie_nx   = 1'b0;
        end else if (!gie || !en8[idx]) begin
          state_nx = IDLE;
          irq_nx   = 1'b0;
        end
      end
      SERVICE: begin
        if (ctrl_wr && reg_wdata[0]) begin
          state_nx = IDLE;
          act_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        irq_nx   = 1'b0;
        act_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      enable     <= '0;
      pending    <= '0;
      gie        <= 1'b0;
      idx        <= '0;
      interrupt  <= 1'b0;
      int_active <= 1'b0;
      int_vector <= '0;
    end else begin
      state      <= state_nx;
      s1         <= irq_in;
      s2         <= s1;
      s3         <= s2;
      pending    <= pending_nx;
      gie        <= gie_nx;
      idx        <= idx_nx;
      interrupt  <= irq_nx;
      int_active <= act_nx;
      int_vector <= vec_nx;
      if (reg_we && reg_addr == 2'd0)
        enable <= reg_wdata[NUM_IRQ-1:0];
    end
  end

`ifdef F8_INTC_LEVEL_EN
  always_ff @(posedge clk) begin
    if (reset)
      edge_sel <= '0;
    else if (reg_we && reg_addr == 2'd2)
      edge_sel <= reg_wdata[NUM_IRQ-1:0];
  end
`endif

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      2'd0: reg_rdata = en8;
      2'd1: reg_rdata = pend8;
      2'd2: reg_rdata = esel8;
      2'd3: reg_rdata = {gie, int_active, 3'b000, idx};
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_f8_intc.sv
// Directed self-checking bench for f8_intc.
// Works with or without F8_INTC_LEVEL_EN defined.
module tb_f8_intc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = '0;
  logic [1:0]  reg_addr = '0;
  logic [7:0]  reg_wdata = '0;
  logic        reg_we = 1'b0;
  logic [7:0]  reg_rdata;
  logic        interrupt;
  logic [15:0] int_vector;
  logic        int_ack = 1'b0;
  logic        int_active;

  int checks = 0;
  int failures = 0;

  f8_intc dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_rdata(reg_rdata),
    .interrupt(interrupt),
    .int_vector(int_vector),
    .int_ack(int_ack),
    .int_active(int_active)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    irq_in = '0;
    int_ack = 1'b0;
    reg_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_we = 1'b1;
    reg_addr = a;
    reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic edge_all();
`ifdef F8_INTC_LEVEL_EN
    wr(2'd2, 8'hFF);
`endif
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq_in = m;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    checks++;
    if ({interrupt, int_active, int_vector} !== 18'h0) begin
      failures++;
      $display("FAIL reset_outs got=%b/%b/%h exp=0/0/0000",
               interrupt, int_active, int_vector);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=00", a, d);
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] d;
    do_reset();
    edge_all();
    wr(2'd0, 8'h01);
    wr(2'd3, 8'h80);
    @(negedge clk);
    irq_in = 8'h01;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      irq_in = '0;
      checks++;
      if (interrupt !== 1'b0) begin
        failures++;
        $display("FAIL lat_early_E%0d got=%b exp=0", e, interrupt);
      end
    end
    @(negedge clk);
    checks++;
    if (interrupt !== 1'b1 || int_vector !== 16'h0010) begin
      failures++;
      $display("FAIL lat_E3 got=%b/%h exp=1/0010", interrupt, int_vector);
    end
    rd(2'd1, d);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("FAIL lat_pending got=%h exp=01", d);
    end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    do_reset();
    edge_all();
    wr(2'd0, 8'hFF);
    pulse(8'h24);
    repeat (4) @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h24 || interrupt !== 1'b0) begin
      failures++;
      $display("FAIL prio_pend got=%h/%b exp=24/0", d, interrupt);
    end
    wr(2'd3, 8'h80);
    @(negedge clk);
    checks++;
    if (interrupt !== 1'b1 || int_vector !== 16'h0018) begin
      failures++;
      $display("FAIL prio_vec got=%b/%h exp=1/0018", interrupt, int_vector);
    end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    checks++;
    if (interrupt !== 1'b0 || int_active !== 1'b1) begin
      failures++;
      $display("FAIL ack_outs got=%b/%b exp=0/1", interrupt, int_active);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 8'h42) begin
      failures++;
      $display("FAIL ack_ctrl got=%h exp=42", d);
    end
    rd(2'd1, d);
    checks++;
    if (d !== 8'h20) begin
      failures++;
      $display("FAIL ack_pend got=%h exp=20", d);
    end
  endtask

  task automatic test_eoi();
    logic [7:0] d;
    wr(2'd3, 8'h81);
    checks++;
    if (int_active !== 1'b0 || interrupt !== 1'b0) begin
      failures++;
      $display("FAIL eoi_outs got=%b/%b exp=0/0", int_active, interrupt);
    end
    @(negedge clk);
    checks++;
    if (interrupt !== 1'b1 || int_vector !== 16'h0024) begin
      failures++;
      $display("FAIL eoi_next got=%b/%h exp=1/0024", interrupt, int_vector);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 8'h85) begin
      failures++;
      $display("FAIL eoi_ctrl got=%h exp=85", d);
    end
  endtask

  task automatic test_level();
    logic [7:0] d;
    do_reset();
    wr(2'd2, 8'hF7);
    @(negedge clk);
    irq_in = 8'h08;
    repeat (4) @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h08) begin
      failures++;
      $display("FAIL lvl_set got=%h exp=08", d);
    end
`ifdef F8_INTC_LEVEL_EN
    wr(2'd1, 8'h08);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h08) begin
      failures++;
      $display("FAIL lvl_w1c got=%h exp=08", d);
    end
    irq_in = '0;
    repeat (4) @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL lvl_release got=%h exp=00", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 8'hF7) begin
      failures++;
      $display("FAIL lvl_esel got=%h exp=F7", d);
    end
`else
    irq_in = '0;
    repeat (4) @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h08) begin
      failures++;
      $display("FAIL edge_latched got=%h exp=08", d);
    end
    wr(2'd1, 8'h08);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL edge_w1c got=%h exp=00", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL edge_esel got=%h exp=00", d);
    end
`endif
  endtask

  task automatic test_w1c_race();
    logic [7:0] d;
    do_reset();
    edge_all();
    pulse(8'h02);
    repeat (4) @(negedge clk);
    @(negedge clk);
    irq_in = 8'h02;
    @(negedge clk);
    irq_in = '0;
    @(negedge clk);
    reg_we = 1'b1;
    reg_addr = 2'd1;
    reg_wdata = 8'h02;
    @(negedge clk);
    reg_we = 1'b0;
    rd(2'd1, d);
    checks++;
    if (d !== 8'h02) begin
      failures++;
      $display("FAIL race_set_wins got=%h exp=02", d);
    end
    wr(2'd1, 8'h02);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL race_plain_w1c got=%h exp=00", d);
    end
  endtask

  task automatic test_cancel();
    logic [7:0] d;
    do_reset();
    edge_all();
    wr(2'd0, 8'h01);
    wr(2'd3, 8'h80);
    pulse(8'h01);
    repeat (4) @(negedge clk);
    wr(2'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (interrupt !== 1'b0) begin
      failures++;
      $display("FAIL cancel_drop got=%b exp=0", interrupt);
    end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    rd(2'd1, d);
    checks++;
    if (int_active !== 1'b0 || d !== 8'h01) begin
      failures++;
      $display("FAIL cancel_ack_ign got=%b/%h exp=0/01", int_active, d);
    end
  endtask

  task automatic test_reset_in_req();
    logic [7:0] d;
    do_reset();
    edge_all();
    wr(2'd0, 8'h01);
    wr(2'd3, 8'h80);
    pulse(8'h01);
    repeat (3) @(negedge clk);
    checks++;
    if (interrupt !== 1'b1) begin
      failures++;
      $display("FAIL rreq_pre got=%b exp=1", interrupt);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (interrupt !== 1'b0 || int_active !== 1'b0) begin
      failures++;
      $display("FAIL rreq_outs got=%b/%b exp=0/0", interrupt, int_active);
    end
    reset = 1'b0;
    rd(2'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL rreq_pend got=%h exp=00", d);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL rreq_ctrl got=%h exp=00", d);
    end
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    checks++;
    if (int_active !== 1'b0 || interrupt !== 1'b0) begin
      failures++;
      $display("FAIL rreq_ack got=%b/%b exp=0/0", int_active, interrupt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_priority();
    test_eoi();
    test_level();
    test_w1c_race();
    test_cancel();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
